// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-port round-robin arbiter and access sequencer for one async SRAM
//
// Ports:
//   clk, reset_b                 system clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    port A (host) request, direction, address, write data
//   a_ack/a_rdata                port A one-clock completion pulse, read data register
//   b_*                          same as port A, for port B (loader/DMA)
//   sram_addr/sram_dout          registered address and write data to the SRAM
//   sram_dout_en                 1 = CPLD drives the SRAM data bus
//   sram_din                     read data from the SRAM
//   sram_ce_b/oe_b/we_b          registered active-low chip, output and write enables
module sram_bus_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_b,
    output logic              sram_oe_b,
    output logic              sram_we_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    // last_grant: 0 = A, 1 = B. It also names the port owning the access in flight.
    logic              last_grant;
    logic              grant_nxt;
    logic              take;
    logic              lat_we;
    logic              we_nxt;
    logic              strobe_done;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              ce_b_nxt;
    logic              oe_b_nxt;
    logic              we_b_nxt;
    logic              dout_en_nxt;
    logic              a_ack_nxt;
    logic              b_ack_nxt;

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= grant_nxt;
            lat_we     <= we_nxt;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = last_grant;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    take      = 1'b1;
                    // On a tie the port that did not win last time goes next
                    grant_nxt = (a_req && b_req) ? ~last_grant : b_req;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = STROBE;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign strobe_done = (state == STROBE) && (cnt == 4'd0);

    // Output logic: next values of the pin registers, derived from the next state
    // so every SRAM pin comes straight from a flop.
    always_comb begin
        we_nxt   = lat_we;
        addr_nxt = sram_addr;
        dout_nxt = sram_dout;
        if (take) begin
            we_nxt   = grant_nxt ? b_we : a_we;
            addr_nxt = grant_nxt ? b_addr : a_addr;
            if (we_nxt) begin
                dout_nxt = grant_nxt ? b_wdata : a_wdata;
            end
        end
        ce_b_nxt    = (state_nxt == IDLE);
        oe_b_nxt    = !((state_nxt == STROBE) && !we_nxt);
        we_b_nxt    = !((state_nxt == STROBE) && we_nxt);
        // Write data stays driven through HOLD for data hold time
        dout_en_nxt = (state_nxt != IDLE) && we_nxt;
        a_ack_nxt   = strobe_done && !last_grant;
        b_ack_nxt   = strobe_done && last_grant;
    end

    // Pin and handshake registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            sram_ce_b    <= 1'b1;
            sram_oe_b    <= 1'b1;
            sram_we_b    <= 1'b1;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else begin
            sram_addr    <= addr_nxt;
            sram_dout    <= dout_nxt;
            sram_dout_en <= dout_en_nxt;
            sram_ce_b    <= ce_b_nxt;
            sram_oe_b    <= oe_b_nxt;
            sram_we_b    <= we_b_nxt;
            a_ack        <= a_ack_nxt;
            b_ack        <= b_ack_nxt;
            // Read data is captured on the edge that ends the strobe
            if (strobe_done && !lat_we && !last_grant) begin
                a_rdata <= sram_din;
            end
            if (strobe_done && !lat_we && last_grant) begin
                b_rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
    localparam int AW  = 19;
    localparam int DW  = 8;
    localparam int ACC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_b;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout, sram_din;
    logic          sram_dout_en, sram_ce_b, sram_oe_b, sram_we_b;

    // Second instance built with the minimum strobe length
    logic          a1_req, a1_we, b1_req, b1_we;
    logic [AW-1:0] a1_addr, b1_addr;
    logic [DW-1:0] a1_wdata, b1_wdata;
    logic          a1_ack, b1_ack;
    logic [DW-1:0] a1_rdata, b1_rdata;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_dout, s1_din;
    logic          s1_dout_en, s1_ce_b, s1_oe_b, s1_we_b;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) u_dut (
        .clk(clk), .reset_b(reset_b),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .sram_ce_b(sram_ce_b), .sram_oe_b(sram_oe_b),
        .sram_we_b(sram_we_b)
    );

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_b(reset_b),
        .a_req(a1_req), .a_we(a1_we), .a_addr(a1_addr), .a_wdata(a1_wdata),
        .a_ack(a1_ack), .a_rdata(a1_rdata),
        .b_req(b1_req), .b_we(b1_we), .b_addr(b1_addr), .b_wdata(b1_wdata),
        .b_ack(b1_ack), .b_rdata(b1_rdata),
        .sram_addr(s1_addr), .sram_dout(s1_dout), .sram_dout_en(s1_dout_en),
        .sram_din(s1_din), .sram_ce_b(s1_ce_b), .sram_oe_b(s1_oe_b),
        .sram_we_b(s1_we_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [7:0] init_val(input logic [AW-1:0] addr);
        return addr[7:0] ^ addr[15:8] ^ 8'h5A;
    endfunction

    // SRAM pin model: junk on the bus while OE is high, writes latched during WE low
    logic [DW-1:0] smem [logic [AW-1:0]];
    function automatic logic [7:0] smem_rd(input logic [AW-1:0] addr);
        return smem.exists(addr) ? smem[addr] : init_val(addr);
    endfunction
    always @(negedge clk) begin
        sram_din = sram_oe_b ? 8'hEE : smem_rd(sram_addr);
        s1_din   = s1_oe_b ? 8'hEE : init_val(s1_addr);
        if (!sram_ce_b && !sram_we_b && sram_dout_en) smem[sram_addr] = sram_dout;
    end

    // Reference model: one access spans cycles s+1..s+ACC+2 after the request is seen in
    // IDLE at cycle s, strobe in s+2..s+ACC+1, ack in s+ACC+2, idle again at s+ACC+3.
    logic [DW-1:0] rmem [logic [AW-1:0]];
    function automatic logic [7:0] rmem_rd(input logic [AW-1:0] addr);
        return rmem.exists(addr) ? rmem[addr] : init_val(addr);
    endfunction

    int            cyc = 0;
    int            m_s = -1;
    bit            m_port, m_we, m_last = 1'b1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] exp_a_rd = '0, exp_b_rd = '0;
    bit            grants[$];
    int            ack_cyc[$];
    int            n_ack_a = 0;
    bit            auto_a = 0, auto_b = 0, keep = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_busy();
        int p;
        p = (m_s >= 0) ? cyc - m_s : -1;
        return (p >= 1) && (p <= ACC + 2);
    endfunction

    task automatic new_a();
        a_req = 1'b1; a_we = 1'($urandom); a_addr = AW'($urandom_range(0, 15)); a_wdata = 8'($urandom);
    endtask
    task automatic new_b();
        b_req = 1'b1; b_we = 1'($urandom); b_addr = AW'($urandom_range(0, 15)); b_wdata = 8'($urandom);
    endtask

    task automatic tick();
        int p;
        bit busy;
        @(posedge clk);
        cyc++;
        if (reset_b && (m_s < 0 || cyc - 1 >= m_s + ACC + 3)) begin
            m_s = -1;
            if (a_req || b_req) begin
                m_port = (a_req && b_req) ? !m_last : b_req;
                m_last = m_port;
                m_s    = cyc - 1;
                m_we   = m_port ? b_we : a_we;
                m_addr = m_port ? b_addr : a_addr;
                m_data = m_port ? b_wdata : a_wdata;
            end
        end
        #1;
        p    = (m_s >= 0) ? cyc - m_s : -1;
        busy = model_busy();
        if (busy && p == ACC + 2) begin
            if (m_we) rmem[m_addr] = m_data;
            else if (m_port) exp_b_rd = rmem_rd(m_addr);
            else exp_a_rd = rmem_rd(m_addr);
            grants.push_back(m_port);
            ack_cyc.push_back(cyc);
        end
        chk("ce_b", 32'(sram_ce_b), 32'(!busy));
        chk("oe_b", 32'(sram_oe_b), 32'(!(busy && p >= 2 && p <= ACC + 1 && !m_we)));
        chk("we_b", 32'(sram_we_b), 32'(!(busy && p >= 2 && p <= ACC + 1 && m_we)));
        chk("dout_en", 32'(sram_dout_en), 32'(busy && m_we));
        chk("a_ack", 32'(a_ack), 32'(busy && p == ACC + 2 && !m_port));
        chk("b_ack", 32'(b_ack), 32'(busy && p == ACC + 2 && m_port));
        chk("a_rdata", 32'(a_rdata), 32'(exp_a_rd));
        chk("b_rdata", 32'(b_rdata), 32'(exp_b_rd));
        if (busy) chk("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (busy && m_we) chk("sram_dout", 32'(sram_dout), 32'(m_data));
        if (a_ack) n_ack_a++;
        if (auto_a) begin
            if (a_ack) begin
                if (keep || $urandom_range(0, 3) != 0) new_a(); else a_req = 1'b0;
            end else if (!a_req) begin
                if ($urandom_range(0, 2) == 0) new_a();
            end else if (!keep && !(busy && !m_port) && $urandom_range(0, 9) == 0) a_req = 1'b0;
        end
        if (auto_b) begin
            if (b_ack) begin
                if (keep || $urandom_range(0, 3) != 0) new_b(); else b_req = 1'b0;
            end else if (!b_req) begin
                if ($urandom_range(0, 2) == 0) new_b();
            end else if (!keep && !(busy && m_port) && $urandom_range(0, 9) == 0) b_req = 1'b0;
        end
    endtask

    task automatic wait_ack(input bit port, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(port ? b_ack : a_ack) && n < 60);
        chk(tag, 32'(port ? b_ack : a_ack), 32'd1);
    endtask

    // Asynchronous reset mid-cycle; a write cut short leaves memory undefined
    task automatic apply_reset();
        #3;
        if (model_busy() && m_we) begin
            smem.delete(m_addr);
            rmem.delete(m_addr);
        end
        reset_b  = 1'b0;
        m_s      = -1;
        m_last   = 1'b1;
        exp_a_rd = '0;
        exp_b_rd = '0;
        #1;
        chk("rst_ce_b", 32'(sram_ce_b), 32'd1);
        chk("rst_oe_b", 32'(sram_oe_b), 32'd1);
        chk("rst_we_b", 32'(sram_we_b), 32'd1);
        chk("rst_dout_en", 32'(sram_dout_en), 32'd0);
        chk("rst_acks", 32'({a_ack, b_ack}), 32'd0);
        tick();
        tick();
        reset_b = 1'b1;
    endtask

    initial begin
        int t0;
        int t1a, t1b, oe_cnt;
        reset_b = 1'b0;
        {a_req, a_we, a_addr, a_wdata} = '0;
        {b_req, b_we, b_addr, b_wdata} = '0;
        {a1_req, a1_we, a1_addr, a1_wdata} = '0;
        {b1_req, b1_we, b1_addr, b1_wdata} = '0;
        tick();
        tick();
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dout", 32'(sram_dout), 32'd0);
        reset_b = 1'b1;

        // Single A write
        a_req = 1'b1; a_we = 1'b1; a_addr = 19'h12345; a_wdata = 8'hA5;
        t0 = cyc;
        wait_ack(1'b0, "t1_ack");
        chk("t1_latency", 32'(cyc - t0), 32'(ACC + 2));
        a_req = 1'b0;
        tick();
        chk("t1_mem", 32'(smem_rd(19'h12345)), 32'hA5);

        // Single B read
        smem[19'h00010] = 8'h3C;
        rmem[19'h00010] = 8'h3C;
        b_req = 1'b1; b_we = 1'b0; b_addr = 19'h00010;
        wait_ack(1'b1, "t2_ack");
        chk("t2_b_rdata", 32'(b_rdata), 32'h3C);
        chk("t2_a_rdata", 32'(a_rdata), 32'h00);
        b_req = 1'b0;
        tick();

        // Both ports continuously from reset: strict alternation starting with A
        apply_reset();
        grants.delete();
        ack_cyc.delete();
        new_a();
        new_b();
        auto_a = 1; auto_b = 1; keep = 1;
        for (int n = 0; n < 80 && grants.size() < 4; n++) tick();
        auto_a = 0; auto_b = 0; keep = 0;
        a_req = 1'b0; b_req = 1'b0;
        chk("t3_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk("t3_order", 32'(grants[i]), 32'(i % 2));
            if (i > 0) chk("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(ACC + 3));
        end
        repeat (ACC + 4) tick();

        // Reset in the middle of a write strobe with B waiting
        a_req = 1'b1; a_we = 1'b1; a_addr = 19'h00007; a_wdata = 8'h99;
        tick();
        tick();
        tick();
        chk("t4_in_strobe", 32'(sram_we_b), 32'd0);
        b_req = 1'b1; b_we = 1'b0; b_addr = 19'h00010;
        apply_reset();
        grants.delete();
        wait_ack(1'b0, "t4_a_ack");
        a_req = 1'b0;
        wait_ack(1'b1, "t4_b_ack");
        b_req = 1'b0;
        chk("t4_first_grant", 32'(grants.size() > 0 ? grants[0] : 1'b1), 32'd0);
        chk("t4_b_rdata", 32'(b_rdata), 32'h3C);
        tick();

        // One-cycle pulse on a_req: access still completes exactly once
        t0 = n_ack_a;
        a_req = 1'b1; a_we = 1'b0; a_addr = 19'h00005;
        tick();
        a_req = 1'b0;
        repeat (ACC + 6) tick();
        chk("t5_ack_count", 32'(n_ack_a - t0), 32'd1);
        chk("t5_idle_ce_b", 32'(sram_ce_b), 32'd1);

        // Random traffic on both ports
        auto_a = 1; auto_b = 1;
        repeat (1500) tick();
        auto_a = 0; auto_b = 0;
        a_req = 1'b0; b_req = 1'b0;
        repeat (ACC + 6) tick();

        // ACC_CYCLES=1 build: back-to-back A reads of 0x0 then 0x1
        a1_req = 1'b1; a1_we = 1'b0; a1_addr = 19'h0;
        t1a = -1; t1b = -1; oe_cnt = 0;
        for (int n = 0; n < 30 && t1b < 0; n++) begin
            tick();
            if (!s1_oe_b) oe_cnt++;
            if (a1_ack) begin
                if (t1a < 0) begin
                    t1a = cyc;
                    chk("t6_oe_len0", 32'(oe_cnt), 32'd1);
                    chk("t6_rdata0", 32'(a1_rdata), 32'(init_val(19'h0)));
                    oe_cnt = 0;
                    a1_addr = 19'h1;
                end else begin
                    t1b = cyc;
                    chk("t6_oe_len1", 32'(oe_cnt), 32'd1);
                    chk("t6_rdata1", 32'(a1_rdata), 32'(init_val(19'h1)));
                    a1_req = 1'b0;
                end
            end
        end
        chk("t6_period", 32'(t1b - t1a), 32'd4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- CPLD-resident controller that shares one external asynchronous SRAM between two requesters: port A (host bus interface) and port B (loader/DMA engine).
- Arbitrates between them round-robin and sequences each SRAM access as setup, strobe and hold phases on the breakout's IO pins.
- Targets the xc95108 PLCC84 breakout, with SRAM address, data and strobes mapped to header nets.

Parameters:
- ADDR_W, 19, SRAM address width.
- DATA_W, 8, SRAM data width.
- ACC_CYCLES, 2, number of clocks the OE/WE strobe is held active. Legal range 1..15; 0 is illegal.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request (level).
- a_we  in  1  port A write=1, read=0.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  port A completion pulse (one clock).
- a_rdata  out  DATA_W  port A read data register.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  data to SRAM.
- sram_dout_en  out  1  data bus drive enable (1 = CPLD drives the bus).
- sram_din  in  DATA_W  data from SRAM.
- sram_ce_b  out  1  chip enable, active-low.
- sram_oe_b  out  1  output enable, active-low.
- sram_we_b  out  1  write enable, active-low.

Behaviour:
- Reset (async, immediate) values:
  - FSM = IDLE.
  - sram_ce_b, sram_oe_b, sram_we_b = 1; sram_dout_en = 0.
  - sram_addr and sram_dout = 0.
  - a_ack and b_ack = 0; a_rdata and b_rdata = 0.
  - last_grant = B, so A wins the first tie.
  - Strobe counter = 0.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - Strobes and ce_b high; dout_en 0.
  - Requests are sampled only in IDLE.
  - If one req is high: grant it.
  - If both are high: grant the port that is not last_grant, then update last_grant.
  - On grant, latch addr, we and wdata into internal registers and go to SETUP.
  - With no req, stay in IDLE.
- SETUP (1 clock):
  - ce_b = 0; sram_addr = latched address; oe_b and we_b high.
  - For a write, dout_en = 1 and sram_dout = latched data.
  - Load the counter with ACC_CYCLES-1.
- STROBE (ACC_CYCLES clocks):
  - Read: oe_b = 0. Write: we_b = 0.
  - The counter decrements each clock; at 0, go to HOLD.
  - Read: sram_din is captured into the granted port's rdata on the clock edge leaving STROBE.
- HOLD (1 clock):
  - oe_b and we_b high; ce_b = 0; address stable; dout_en stays 1 for writes to give data hold time.
  - The granted port's ack = 1 for exactly this clock.
  - Next state IDLE.
- Latency: req seen in IDLE at cycle 0 gives ack in cycle ACC_CYCLES+2. Back-to-back accesses take ACC_CYCLES+3 clocks each.
- Handshake:
  - Requester holds req, we, addr and wdata stable until ack.
  - In the clock after ack it either drops req or presents the next transaction.
  - req dropped before grant: no access, no ack.
  - req dropped after grant: the access still completes and ack is still pulsed.
- Simultaneous events:
  - Both ports requesting continuously are served strictly alternately, so neither starves.
  - a_ack and b_ack are never high in the same cycle.
- rdata registers change only on a read completion for that port; they hold across writes and the other port's accesses.
- sram_addr and sram_dout hold their last values in IDLE (no glitching needed); ce_b = 1 in IDLE.
- Reset mid-access:
  - Strobes deassert and dout_en drops asynchronously, with no ack.
  - After reset_b rises, the FSM starts in IDLE and any write in progress is undefined in memory.
- No combinational path from req to any SRAM pin; all SRAM outputs are registered.

Test Plan:
- ACC_CYCLES=2; A write addr 0x12345 data 0xA5 -> ce_b low cycles 1-4; we_b low cycles 2-3; dout_en 1 cycles 1-4; a_ack=1 at cycle 4 only; b_ack stays 0.
- B read addr 0x00010, SRAM model returns 0x3C -> oe_b low 2 clocks; b_rdata=0x3C when b_ack rises; a_rdata unchanged (0x00).
- a_req and b_req rise in the same cycle after reset, both held with new transactions -> grant order A,B,A,B; acks 5 clocks apart; never both high.
- Async reset asserted mid-STROBE of a write -> we_b=1, ce_b=1, dout_en=0 before the next clk edge; no ack; after release, a pending b_req is served from IDLE with A-priority tie rule.
- a_req pulsed 1 cycle in IDLE (dropped after grant) -> full access runs, a_ack pulses once; the following IDLE with no req stays idle with ce_b=1.
- ACC_CYCLES=1 rebuild, back-to-back A reads to 0x0,0x1 -> 4-clock period, oe_b low 1 clock each, a_rdata updated per read.
